// File: rtl/mem_wb_stage.sv
// Memory and writeback stages of the RV32I pipeline: word-addressed data RAM,
// MEM/WB pipeline register and the writeback result mux.
module mem_wb_stage #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write_m,
    input  logic        mem_write_m,
    input  logic [1:0]  result_src_m,
    input  logic [4:0]  rd_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] write_data_m,
    input  logic [31:0] pc_plus4_m,
    output logic        reg_write_w,
    output logic [4:0]  rd_w,
    output logic [31:0] result_w,
    output logic [31:0] read_data_w
);

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_LOAD = 2'b01,
        SRC_PC4  = 2'b10,
        SRC_RSVD = 2'b11
    } result_src_e;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  rd;
        logic [1:0]  result_src;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus4;
    } mem_wb_t;

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              store_en;
    logic [31:0]       read_data_m;
    mem_wb_t           wb_d;
    mem_wb_t           wb_q;
    logic              unused_byte_offset;

    // Word access only: the byte offset is dropped, so misaligned addresses alias.
    assign idx                = alu_result_m[ADDR_W+1:2];
    assign in_range           = (alu_result_m[31:ADDR_W+2] == '0);
    assign unused_byte_offset = ^alu_result_m[1:0];

    // Stores are suppressed while reset is held; the array itself is never cleared.
    assign store_en = mem_write_m && in_range && !rst;

    always_ff @(posedge clk) begin
        if (store_en) begin
            mem_q[idx] <= write_data_m;
        end
    end

    assign read_data_m = in_range ? mem_q[idx] : 32'h0000_0000;

    always_comb begin
        wb_d            = '0;
        wb_d.reg_write  = reg_write_m;
        wb_d.rd         = rd_m;
        wb_d.result_src = result_src_m;
        wb_d.alu_result = alu_result_m;
        wb_d.read_data  = read_data_m;
        wb_d.pc_plus4   = pc_plus4_m;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    // A cleared register selects the ALU path with a zero value, so result_w is 0 in reset.
    always_comb begin
        result_w = wb_q.alu_result;
        case (result_src_e'(wb_q.result_src))
            SRC_ALU:  result_w = wb_q.alu_result;
            SRC_LOAD: result_w = wb_q.read_data;
            SRC_PC4:  result_w = wb_q.pc_plus4;
            SRC_RSVD: result_w = wb_q.alu_result;
            default:  result_w = wb_q.alu_result;
        endcase
    end

    assign reg_write_w = wb_q.reg_write;
    assign rd_w        = wb_q.rd;
    assign read_data_w = wb_q.read_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed plan items plus a randomized
// instruction stream checked against a word-map reference model.
module tb_mem_wb_stage;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_m;
    logic        mem_write_m;
    logic [1:0]  result_src_m;
    logic [4:0]  rd_m;
    logic [31:0] alu_result_m;
    logic [31:0] write_data_m;
    logic [31:0] pc_plus4_m;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic [31:0] read_data_w;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference memory: word index -> last stored value; absent means never written.
    logic [31:0] ref_mem [int];
    int          written [$];

    logic        exp_rw;
    logic [4:0]  exp_rd;
    logic [31:0] exp_res;
    logic [31:0] exp_rdata;
    bit          exp_rdata_known;

    mem_wb_stage #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_write_m  (reg_write_m),
        .mem_write_m  (mem_write_m),
        .result_src_m (result_src_m),
        .rd_m         (rd_m),
        .alu_result_m (alu_result_m),
        .write_data_m (write_data_m),
        .pc_plus4_m   (pc_plus4_m),
        .reg_write_w  (reg_write_w),
        .rd_w         (rd_w),
        .result_w     (result_w),
        .read_data_w  (read_data_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic mw, input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4);
        reg_write_m  = rw;
        mem_write_m  = mw;
        result_src_m = src;
        rd_m         = rd;
        alu_result_m = alu;
        write_data_m = wd;
        pc_plus4_m   = pc4;
    endtask

    // Predict what W holds after the next edge, advance one clock, then compare.
    task automatic cycle(input string tag);
        logic [31:0] ld;
        bit          in_rng;
        bit          known;
        int          widx;
        if (rst) begin
            exp_rw = 1'b0; exp_rd = 5'd0; exp_res = 32'd0; exp_rdata = 32'd0; exp_rdata_known = 1'b1;
        end else begin
            in_rng = (alu_result_m < 32'(4 * DEPTH));
            widx   = int'(alu_result_m / 4);
            if (!in_rng) begin
                ld = 32'd0; known = 1'b1;
            end else if (ref_mem.exists(widx)) begin
                ld = ref_mem[widx]; known = 1'b1;
            end else begin
                ld = 32'd0; known = 1'b0;
            end
            exp_rw          = reg_write_m;
            exp_rd          = rd_m;
            exp_rdata       = ld;
            exp_rdata_known = known;
            if (result_src_m == 2'b01)      exp_res = ld;
            else if (result_src_m == 2'b10) exp_res = pc_plus4_m;
            else                            exp_res = alu_result_m;
            if (mem_write_m && in_rng) begin
                ref_mem[widx] = write_data_m;
                written.push_back(widx);
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".rw"}, 32'(reg_write_w), 32'(exp_rw));
        chk({tag, ".rd"}, 32'(rd_w), 32'(exp_rd));
        if (exp_rdata_known) begin
            chk({tag, ".res"}, result_w, exp_res);
            chk({tag, ".rdata"}, read_data_w, exp_rdata);
        end else if (result_src_m != 2'b01) begin
            chk({tag, ".res"}, result_w, exp_res);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".rw"}, 32'(reg_write_w), 32'd0);
        chk({tag, ".rd"}, 32'(rd_w), 32'd0);
        chk({tag, ".res"}, result_w, 32'd0);
        chk({tag, ".rdata"}, read_data_w, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
        #1;
        check_zero("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset response: load W with nonzero values, then assert reset between edges.
        drive(1'b1, 1'b0, 2'b10, 5'd9, 32'h0000_2000, 32'h5555_5555, 32'h0000_0ABC);
        cycle("pre_rst");
        chk("pre_rst.pc4", result_w, 32'h0000_0ABC);
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        cycle("hold_rst");
        check_zero("hold_rst2");
        rst = 1'b0;
        cycle("post_rst");
        chk("post_rst.first", result_w, 32'h0000_0ABC);

        // Word 0 seeded for the out-of-range check.
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h0000_0000, 32'hA5A5_A5A5, 32'h4);
        cycle("sw0");

        // Store then load.
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h8);
        cycle("sw10");
        drive(1'b1, 1'b0, 2'b01, 5'd5, 32'h0000_0010, 32'h0, 32'hC);
        cycle("lw10");
        chk("st_ld.res", result_w, 32'hDEAD_BEEF);
        chk("st_ld.rd", 32'(rd_w), 32'd5);
        chk("st_ld.rw", 32'(reg_write_w), 32'd1);

        // ALU passthrough then PC+4.
        drive(1'b1, 1'b0, 2'b00, 5'd7, 32'h1234_5678, 32'h0, 32'h100);
        cycle("alu");
        chk("alu.res", result_w, 32'h1234_5678);
        drive(1'b1, 1'b0, 2'b10, 5'd1, 32'h0000_0040, 32'h0, 32'h0000_0104);
        cycle("pc4");
        chk("pc4.res", result_w, 32'h0000_0104);

        // Reserved select falls back to the ALU value.
        drive(1'b1, 1'b0, 2'b11, 5'd3, 32'h0BAD_CAFE, 32'h0, 32'h0000_0200);
        cycle("src11");
        chk("src11.res", result_w, 32'h0BAD_CAFE);

        // Out of range: store dropped, load returns 0, word 0 intact.
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0);
        cycle("sw_oor");
        drive(1'b1, 1'b0, 2'b01, 5'd6, 32'h0000_1000, 32'h0, 32'h0);
        cycle("lw_oor");
        chk("oor.res", result_w, 32'h0000_0000);
        drive(1'b1, 1'b0, 2'b01, 5'd6, 32'h0000_0000, 32'h0, 32'h0);
        cycle("lw0");
        chk("oor.word0", result_w, 32'hA5A5_A5A5);

        // Misaligned alias.
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h0000_0022, 32'hCAFE_F00D, 32'h0);
        cycle("sw22");
        drive(1'b1, 1'b0, 2'b01, 5'd8, 32'h0000_0020, 32'h0, 32'h0);
        cycle("lw20");
        chk("alias.res", result_w, 32'hCAFE_F00D);

        // Reset mid-operation with a store held on the inputs.
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h0000_0040, 32'h1111_1111, 32'h0);
        cycle("sw40");
        drive(1'b1, 1'b1, 2'b00, 5'd2, 32'h0000_0040, 32'h2222_2222, 32'h0);
        rst = 1'b1;
        cycle("rst_st1");
        cycle("rst_st2");
        rst = 1'b0;
        drive(1'b1, 1'b0, 2'b01, 5'd4, 32'h0000_0040, 32'h0, 32'h0);
        cycle("lw40");
        chk("rst_mid.res", result_w, 32'h1111_1111);

        // Randomized instruction stream.
        for (int i = 0; i < 400; i++) begin
            int          kind;
            int          widx;
            logic [31:0] a;
            kind = int'($urandom_range(9));
            if ($urandom_range(39) == 0) begin
                drive(1'($urandom), 1'b1, 2'($urandom), 5'($urandom), 32'($urandom_range(255)) << 2,
                      $urandom, $urandom);
                rst = 1'b1;
                #1;
                check_zero("rnd_async");
                cycle("rnd_rst");
                rst = 1'b0;
            end
            case (kind)
                0, 1: begin
                    widx = int'($urandom_range(63));
                    a = 32'(widx * 4) + 32'($urandom_range(3));
                    if ($urandom_range(7) == 0) a = $urandom | 32'h0000_1000;
                    drive(1'b0, 1'b1, 2'($urandom), 5'($urandom), a, $urandom, $urandom);
                end
                2, 3, 4: begin
                    if (written.size() == 0 || $urandom_range(5) == 0) begin
                        a = $urandom | 32'h0000_1000;
                    end else begin
                        widx = written[$urandom_range(written.size() - 1)];
                        a = 32'(widx * 4) + 32'($urandom_range(3));
                    end
                    drive(1'b1, 1'b0, 2'b01, 5'($urandom), a, $urandom, $urandom);
                end
                5, 6: drive(1'b1, 1'b0, 2'b00, 5'($urandom), $urandom, $urandom, $urandom);
                7:    drive(1'b1, 1'b0, 2'b10, 5'($urandom), $urandom, $urandom, $urandom);
                8:    drive(1'b1, 1'b0, 2'b11, 5'($urandom), $urandom, $urandom, $urandom);
                default: drive(1'b0, 1'b0, 2'b00, 5'd0, $urandom, $urandom, $urandom);
            endcase
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus writeback stage of the 5-stage RV32I pipeline. Directly downstream of the execute stage.
- Consumes the EX/MEM pipeline outputs and performs data-memory stores and loads through an internal word-addressed RAM.
- Registers results into the MEM/WB pipeline register and produces the writeback result.
- result_w is fed back to the register file and to the execute-stage forwarding muxes.

Parameters:
- DEPTH, 1024, number of 32-bit words in the data memory (power of 2).
- ADDR_W, 10, word-index width; must equal log2(DEPTH).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- reg_write_m  in  1  register-write enable of the instruction in M.
- mem_write_m  in  1  store enable of the instruction in M.
- result_src_m  in  2  writeback select: 00 ALU, 01 load data, 10 PC+4, 11 reserved.
- rd_m  in  5  destination register of the instruction in M.
- alu_result_m  in  32  effective address (load/store) or ALU result.
- write_data_m  in  32  store data (already forwarded upstream).
- pc_plus4_m  in  32  PC+4 of the instruction in M (jal/jalr link value).
- reg_write_w  out  1  register-write enable to the register file.
- rd_w  out  5  destination register to the register file.
- result_w  out  32  writeback data to the register file and the forwarding muxes.
- read_data_w  out  32  registered load data (debug/trace).

Behaviour:
- Address decode:
  - word index = alu_result_m[ADDR_W+1:2]; alu_result_m[1:0] are ignored (word access only, no byte/half support).
  - in-range iff alu_result_m[31:ADDR_W+2] == 0.
- Store:
  - Condition: mem_write_m=1 and in-range.
  - Memory word is updated at the rising clk edge.
  - Out-of-range store is silently dropped; no other state changes.
  - A store is not blocked by rst=0; during rst=1, stores are suppressed.
- Load read:
  - Combinational from the array using the current index.
  - Out-of-range read returns 32'h0000_0000.
  - A store at edge N is visible to a load in M during cycle N+1 (no bypass needed; only one instruction occupies M).
- Memory contents are not cleared by rst and hold across reset. Before the first write, contents are undefined; the bench never reads unwritten words.
- MEM/WB register, latency 1 cycle. Each rising edge with rst=0 captures reg_write_m, rd_m, result_src_m, alu_result_m, read data and pc_plus4_m.
- Writeback mux (combinational on the registered values):
  - result_src 00 -> ALU result.
  - 01 -> read data.
  - 10 -> PC+4.
  - 11 -> ALU result.
- reg_write_w and rd_w pass through unchanged. x0 suppression is the register file's job.
- Reset (async, immediate on rst rising):
  - All MEM/WB registers clear to 0, so reg_write_w=0, rd_w=0, result_w=0, read_data_w=0.
  - This holds for as long as rst=1.
  - Reset asserted mid-stream discards the instruction in W. The first edge after rst falls captures the M inputs normally.
- No stall/flush inputs. Bubbles arrive from upstream as reg_write_m=0, mem_write_m=0.

Test Plan:
- Reset:
  - Stimulus: assert rst with all inputs nonzero; release.
  - Required: reg_write_w=0, rd_w=0, result_w=0 immediately, without a clk edge. The first edge after release captures the inputs.
- Store then load:
  - Stimulus: sw with alu_result_m=0x0000_0010, write_data_m=0xDEAD_BEEF. Next cycle, lw x5 from 0x10 with result_src_m=01, reg_write_m=1.
  - Required: one cycle later, result_w=0xDEAD_BEEF, rd_w=5, reg_write_w=1.
- ALU passthrough and PC+4:
  - Stimulus: result_src_m=00, alu_result_m=0x1234_5678, rd_m=7. Next cycle, result_src_m=10, pc_plus4_m=0x0000_0104.
  - Required: result_w=0x1234_5678, then 0x0000_0104, each 1 cycle after its input.
- Out-of-range:
  - Stimulus: sw to 0x0000_1000 (DEPTH=1024), then lw from 0x0000_1000; also lw from 0x0.
  - Required: the first load yields result_w=0. Word 0 is unchanged, verified by an earlier write of 0xA5A5_A5A5 read back.
- Misaligned alias:
  - Stimulus: sw 0xCAFE_F00D to 0x22.
  - Required: lw from 0x20 returns 0xCAFE_F00D.
- Reset mid-operation:
  - Stimulus: sw 0x1111_1111 to 0x40; assert rst for 2 cycles with mem_write_m=1 and data 0x2222_2222 held; release; lw 0x40.
  - Required: result_w=0x1111_1111. Memory is retained across reset and the store during reset is suppressed.
